// File: rtl/thumb_decode.sv
// rtl/thumb_decode.sv - registered decoder for a subset of 16-bit Thumb instructions
//
// Converts one Thumb halfword per cycle into a micro-op, register-file port
// selects and an extended immediate. All outputs are registered (1-cycle
// latency); unsupported encodings raise explose for that decode only.
//
// Optional feature macro: DECODE_BCOND_EN
//   defined   : 1101 cond<14 decodes to BCOND (uop = 16 + cond)
//   undefined : every 1101xxxx encoding raises explose
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset, clears all outputs
//   instruction  in   [15:0] halfword to decode
//   uop          out  [4:0]  micro-op code (0 NOP .. 9 B, 16+cond BCOND)
//   num_to_rhs   out  ALU right operand is num (1) or read port p1 (0)
//   num          out  [31:0] decoded immediate / offset
//   sel_p0       out  [3:0]  read port 0 index (15 = PC)
//   sel_p1       out  [3:0]  read port 1 index
//   sel_in       out  [3:0]  destination index (15 = PC)
//   explose      out  illegal / unsupported instruction flag

module thumb_decode (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] instruction,
   output logic [4:0]  uop,
   output logic        num_to_rhs,
   output logic [31:0] num,
   output logic [3:0]  sel_p0,
   output logic [3:0]  sel_p1,
   output logic [3:0]  sel_in,
   output logic        explose
);

   localparam logic [4:0] UOP_NOP = 5'd0;
   localparam logic [4:0] UOP_ADD = 5'd1;
   localparam logic [4:0] UOP_SUB = 5'd2;
   localparam logic [4:0] UOP_CMP = 5'd3;
   localparam logic [4:0] UOP_EOR = 5'd4;
   localparam logic [4:0] UOP_LSL = 5'd5;
   localparam logic [4:0] UOP_MOV = 5'd6;
   localparam logic [4:0] UOP_LDR = 5'd7;
   localparam logic [4:0] UOP_STR = 5'd8;
   localparam logic [4:0] UOP_B   = 5'd9;

   logic [4:0]  uop_d, uop_q;
   logic        num_to_rhs_d, num_to_rhs_q;
   logic [31:0] num_d, num_q;
   logic [3:0]  sel_p0_d, sel_p0_q;
   logic [3:0]  sel_p1_d, sel_p1_q;
   logic [3:0]  sel_in_d, sel_in_q;
   logic        explose_d, explose_q;

   logic [3:0] f_rd, f_rn, f_rm, f_hi;
   logic [4:0] f_imm5;

   assign f_rd   = {1'b0, instruction[2:0]};
   assign f_rn   = {1'b0, instruction[5:3]};
   assign f_rm   = {1'b0, instruction[8:6]};
   assign f_hi   = {1'b0, instruction[10:8]};
   assign f_imm5 = instruction[10:6];

   always_comb begin
      uop_d        = UOP_NOP;
      num_to_rhs_d = 1'b0;
      num_d        = 32'd0;
      sel_p0_d     = 4'd0;
      sel_p1_d     = 4'd0;
      sel_in_d     = 4'd0;
      explose_d    = 1'b0;

      casez (instruction)
         16'b000110?_?????????: begin
            // register ADD/SUB; bit 9 picks SUB
            uop_d    = instruction[9] ? UOP_SUB : UOP_ADD;
            sel_p0_d = f_rn;
            sel_p1_d = f_rm;
            sel_in_d = f_rd;
         end
         16'b000111?_?????????: begin
            uop_d        = instruction[9] ? UOP_SUB : UOP_ADD;
            sel_p0_d     = f_rn;
            sel_in_d     = f_rd;
            num_d        = {29'd0, instruction[8:6]};
            num_to_rhs_d = 1'b1;
         end
         16'b0011?_???????????: begin
            uop_d        = instruction[11] ? UOP_SUB : UOP_ADD;
            sel_p0_d     = f_hi;
            sel_in_d     = f_hi;
            num_d        = {24'd0, instruction[7:0]};
            num_to_rhs_d = 1'b1;
         end
         16'b00101_???????????: begin
            uop_d        = UOP_CMP;
            sel_p0_d     = f_hi;
            num_d        = {24'd0, instruction[7:0]};
            num_to_rhs_d = 1'b1;
         end
         16'b00100_???????????: begin
            uop_d        = UOP_MOV;
            sel_in_d     = f_hi;
            num_d        = {24'd0, instruction[7:0]};
            num_to_rhs_d = 1'b1;
         end
         16'b00000_???????????: begin
            // a zero shift amount is the register MOV alias
            if (f_imm5 == 5'd0) begin
               uop_d    = UOP_MOV;
               sel_p1_d = f_rn;
               sel_in_d = f_rd;
            end else begin
               uop_d        = UOP_LSL;
               sel_p0_d     = f_rn;
               sel_in_d     = f_rd;
               num_d        = {27'd0, f_imm5};
               num_to_rhs_d = 1'b1;
            end
         end
         16'b0100000001_??????: begin
            uop_d    = UOP_EOR;
            sel_p0_d = f_rd;
            sel_in_d = f_rd;
            sel_p1_d = f_rn;
         end
         16'b01101_???????????: begin
            uop_d        = UOP_LDR;
            sel_p0_d     = f_rn;
            sel_in_d     = f_rd;
            num_d        = {25'd0, f_imm5, 2'b00};
            num_to_rhs_d = 1'b1;
         end
         16'b01100_???????????: begin
            uop_d        = UOP_STR;
            sel_p0_d     = f_rn;
            sel_p1_d     = f_rd;
            num_d        = {25'd0, f_imm5, 2'b00};
            num_to_rhs_d = 1'b1;
         end
         16'b11100_???????????: begin
            uop_d        = UOP_B;
            sel_p0_d     = 4'd15;
            sel_in_d     = 4'd15;
            num_d        = {{20{instruction[10]}}, instruction[10:0], 1'b0};
            num_to_rhs_d = 1'b1;
         end
         16'b1101_????????????: begin
`ifdef DECODE_BCOND_EN
            // cond 14/15 are UDF/SVC and stay illegal
            if (instruction[11:8] < 4'd14) begin
               uop_d        = {1'b1, instruction[11:8]};
               sel_p0_d     = 4'd15;
               sel_in_d     = 4'd15;
               num_d        = {{23{instruction[7]}}, instruction[7:0], 1'b0};
               num_to_rhs_d = 1'b1;
            end else begin
               explose_d = 1'b1;
            end
`else
            explose_d = 1'b1;
`endif
         end
         default: explose_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uop_q        <= UOP_NOP;
         num_to_rhs_q <= 1'b0;
         num_q        <= 32'd0;
         sel_p0_q     <= 4'd0;
         sel_p1_q     <= 4'd0;
         sel_in_q     <= 4'd0;
         explose_q    <= 1'b0;
      end else begin
         uop_q        <= uop_d;
         num_to_rhs_q <= num_to_rhs_d;
         num_q        <= num_d;
         sel_p0_q     <= sel_p0_d;
         sel_p1_q     <= sel_p1_d;
         sel_in_q     <= sel_in_d;
         explose_q    <= explose_d;
      end
   end

   assign uop        = uop_q;
   assign num_to_rhs = num_to_rhs_q;
   assign num        = num_q;
   assign sel_p0     = sel_p0_q;
   assign sel_p1     = sel_p1_q;
   assign sel_in     = sel_in_q;
   assign explose    = explose_q;

endmodule

// File: tb/tb_thumb_decode.sv
// tb/tb_thumb_decode.sv - self-checking bench for thumb_decode
//
// Drives directed and random halfwords, compares every registered output
// against a behavioural model. Honours DECODE_BCOND_EN like the design.

module tb_thumb_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instruction = 16'h0000;
   logic [4:0]  uop;
   logic        num_to_rhs;
   logic [31:0] num;
   logic [3:0]  sel_p0, sel_p1, sel_in;
   logic        explose;

   int total = 0;
   int bad = 0;

   thumb_decode dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instruction(instruction),
      .uop        (uop),
      .num_to_rhs (num_to_rhs),
      .num        (num),
      .sel_p0     (sel_p0),
      .sel_p1     (sel_p1),
      .sel_in     (sel_in),
      .explose    (explose)
   );

   always #5 clk = ~clk;

   // packed view: uop, rhs, num, p0, p1, in, explose
   logic [50:0] obs;
   assign obs = {uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, explose};

   function automatic logic [50:0] pack(input int u, input int r, input int n,
                                        input int a, input int b, input int d, input int e);
      logic [4:0]  u5;
      logic [31:0] n32;
      logic [3:0]  a4, b4, d4;
      u5 = u[4:0]; n32 = n; a4 = a[3:0]; b4 = b[3:0]; d4 = d[3:0];
      return {u5, r[0], n32, a4, b4, d4, e[0]};
   endfunction

   // Reference decode built from the field rules with integer arithmetic.
   function automatic logic [50:0] model(input logic [15:0] i);
      int v, top5, top7, rd, rn, rm, imm5, imm8, hi, cnd;
      v    = int'(i);
      top5 = v / 2048;
      top7 = v / 512;
      rd   = v % 8;
      rn   = (v / 8) % 8;
      rm   = (v / 64) % 8;
      imm5 = (v / 64) % 32;
      imm8 = v % 256;
      hi   = (v / 256) % 8;
      cnd  = (v / 256) % 16;
      if (top7 == 12)      return pack(1, 0, 0, rn, rm, rd, 0);
      if (top7 == 13)      return pack(2, 0, 0, rn, rm, rd, 0);
      if (top7 == 14)      return pack(1, 1, rm, rn, 0, rd, 0);
      if (top7 == 15)      return pack(2, 1, rm, rn, 0, rd, 0);
      if (top5 == 6)       return pack(1, 1, imm8, hi, 0, hi, 0);
      if (top5 == 7)       return pack(2, 1, imm8, hi, 0, hi, 0);
      if (top5 == 5)       return pack(3, 1, imm8, hi, 0, 0, 0);
      if (top5 == 4)       return pack(6, 1, imm8, 0, 0, hi, 0);
      if (top5 == 0)
         return (imm5 == 0) ? pack(6, 0, 0, 0, rn, rd, 0) : pack(5, 1, imm5, rn, 0, rd, 0);
      if (v / 64 == 257)   return pack(4, 0, 0, rd, rn, rd, 0);
      if (top5 == 13)      return pack(7, 1, imm5 * 4, rn, 0, rd, 0);
      if (top5 == 12)      return pack(8, 1, imm5 * 4, rn, rd, 0, 0);
      if (top5 == 28)      return pack(9, 1, (((v % 2048) ^ 1024) - 1024) * 2, 15, 0, 15, 0);
`ifdef DECODE_BCOND_EN
      if (v / 4096 == 13 && cnd < 14)
         return pack(16 + cnd, 1, ((imm8 ^ 128) - 128) * 2, 15, 0, 15, 0);
`else
      if (cnd < 0) return '0;
`endif
      return pack(0, 0, 0, 0, 0, 0, 1);
   endfunction

   task automatic drive(input logic [15:0] ins);
      @(negedge clk);
      instruction = ins;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      instruction = 16'h192E;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (obs !== 51'd0) begin
         bad++;
         $display("FAIL reset obs=%h exp=0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      logic [15:0] vec [0:13];
      logic [50:0] exp;
      vec = '{16'h192E, 16'h1D17, 16'h3A65, 16'h2BDC, 16'hE413, 16'hE800, 16'h6911,
              16'h65FE, 16'h051A, 16'h0032, 16'h24D5, 16'hD0FE, 16'h407A, 16'hDE00};
      for (int k = 0; k < 14; k++) begin
         drive(vec[k]);
         exp = model(vec[k]);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL directed ins=%h obs=%h exp=%h", vec[k], obs, exp);
         end
      end
      // spot-check fixed values independently of the model
      drive(16'hE413);
      total++;
      if (uop !== 5'd9 || num !== 32'hFFFFF826 || sel_p0 !== 4'd15 || sel_in !== 4'd15) begin
         bad++;
         $display("FAIL b_offset uop=%0d num=%h exp uop=9 num=fffff826", uop, num);
      end
      drive(16'hD0FE);
      total++;
`ifdef DECODE_BCOND_EN
      if (uop !== 5'd16 || num !== 32'hFFFFFFFC || explose !== 1'b0) begin
         bad++;
         $display("FAIL beq uop=%0d num=%h exp uop=16 num=fffffffc", uop, num);
      end
`else
      if (explose !== 1'b1 || uop !== 5'd0 || num !== 32'd0) begin
         bad++;
         $display("FAIL beq_disabled explose=%b uop=%0d exp explose=1 uop=0", explose, uop);
      end
`endif
      drive(16'h65FE);
      total++;
      if (uop !== 5'd8 || num !== 32'd92 || sel_p0 !== 4'd7 || sel_p1 !== 4'd6) begin
         bad++;
         $display("FAIL str uop=%0d num=%0d p0=%0d p1=%0d exp 8/92/7/6", uop, num, sel_p0, sel_p1);
      end
      drive(16'h0032);
      total++;
      if (uop !== 5'd6 || sel_p1 !== 4'd6 || sel_in !== 4'd2 || num_to_rhs !== 1'b0) begin
         bad++;
         $display("FAIL movreg uop=%0d p1=%0d in=%0d exp 6/6/2", uop, sel_p1, sel_in);
      end
   endtask

   task automatic test_random;
      int prefix [0:15];
      logic [15:0] ins;
      logic [50:0] exp;
      prefix = '{3, 6, 7, 5, 4, 0, 8, 13, 12, 28, 26, 27, 29, 30, 31, 1};
      for (int k = 0; k < 400; k++) begin
         if (k % 2 == 0) begin
            ins = 16'($urandom);
         end else begin
            ins = 16'($urandom);
            ins[15:11] = 5'(prefix[$urandom_range(0, 15)]);
            if (ins[15:11] == 5'd8 && $urandom_range(0, 1) == 1) ins[10:6] = 5'd1;
         end
         drive(ins);
         exp = model(ins);
         total++;
         if (obs !== exp) begin
            bad++;
            $display("FAIL random ins=%h obs=%h exp=%h", ins, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] q [$];
      logic [15:0] ins;
      for (int k = 0; k < 24; k++) q.push_back(16'($urandom));
      @(negedge clk);
      instruction = q[0];
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         ins = q[k];
         total++;
         if (obs !== model(ins)) begin
            bad++;
            $display("FAIL b2b ins=%h obs=%h exp=%h", ins, obs, model(ins));
         end
         @(negedge clk);
         if (k < 23) instruction = q[k + 1];
      end
   endtask

   task automatic test_mid_reset;
      drive(16'h24D5);
      @(negedge clk);
      instruction = 16'hE413;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (obs !== 51'd0) begin
         bad++;
         $display("FAIL mid_reset obs=%h exp=0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      instruction = 16'h2BDC;
      @(posedge clk);
      #1;
      total++;
      if (obs !== model(16'h2BDC)) begin
         bad++;
         $display("FAIL post_reset obs=%h exp=%h", obs, model(16'h2BDC));
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_back_to_back;
      test_mid_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
